fps_stream_arbiter: RTL

- Shares one fps_counter measurement instance between up to four AXI-Stream video sources.
- Forwards exactly one source at a time to the counter's stream input and drains the others so no upstream stalls.
- Switches source only at frame boundaries (tuser = start-of-frame), so the counter always sees whole frames.
- Selection is either fixed or round-robin after a programmable number of frames per source.

---
 rtl/fps_arb_pkg.sv | 23 ++
 rtl/axis_src_mux.sv | 41 ++++
 rtl/fps_stream_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/fps_arb_pkg.sv
// Shared types and constants for the fps_stream_arbiter block.
// The optional HUNT dwell timeout is enabled by defining FPS_ARB_HUNT_TIMEOUT_EN.
package fps_arb_pkg;

    localparam int SEL_WIDTH = 2;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_HUNT     = 2'd1,
        ST_PASS     = 2'd2
    } arb_state_t;

    function automatic logic [SEL_WIDTH-1:0] rr_next(input logic [SEL_WIDTH-1:0] cur,
                                                     input int num_sources);
        if (int'(cur) >= num_sources - 1)
            return '0;
        return cur + 1'b1;
    endfunction

endpackage

// File: rtl/axis_src_mux.sv
// Combinational N-to-1 AXI-Stream select; the selected source gets the gated
// ready, every other source gets the drain ready.
module axis_src_mux
    import fps_arb_pkg::*;
#(
    parameter int NUM_SOURCES     = 2,
    parameter int AXIS_DATA_WIDTH = 8
) (
    input  logic [SEL_WIDTH-1:0]                   i_sel,
    input  logic [NUM_SOURCES-1:0]                 i_src_tuser,
    input  logic [NUM_SOURCES-1:0]                 i_src_tvalid,
    input  logic [NUM_SOURCES-1:0]                 i_src_tlast,
    input  logic [NUM_SOURCES*AXIS_DATA_WIDTH-1:0] i_src_tdata,
    output logic [NUM_SOURCES-1:0]                 o_src_tready,
    input  logic                                   i_sel_tready,
    input  logic                                   i_drain_tready,
    output logic                                   o_tuser,
    output logic                                   o_tvalid,
    output logic                                   o_tlast,
    output logic [AXIS_DATA_WIDTH-1:0]             o_tdata
);

    always_comb begin
        // NOTE: every output gets a default first, so no path through the loop infers a latch.
        o_tuser      = 1'b0;
        o_tvalid     = 1'b0;
        o_tlast      = 1'b0;
        o_tdata      = '0;
        o_src_tready = {NUM_SOURCES{i_drain_tready}};
        for (int k = 0; k < NUM_SOURCES; k++) begin
            if (i_sel == SEL_WIDTH'(k)) begin
                o_tuser         = i_src_tuser[k];
                o_tvalid        = i_src_tvalid[k];
                o_tlast         = i_src_tlast[k];
                o_tdata         = i_src_tdata[k*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
                o_src_tready[k] = i_sel_tready;
            end
        end
    end

endmodule

// File: rtl/fps_stream_arbiter.sv
// Shares one fps_counter between up to four AXIS sources, switching only on SOF.
// Define FPS_ARB_HUNT_TIMEOUT_EN to add the HUNT dwell timeout and o_hunt_timeout.
module fps_stream_arbiter
    import fps_arb_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH  = 8,
    parameter int NUM_SOURCES      = 2,
    parameter int SWITCH_CNT_WIDTH = 16
`ifdef FPS_ARB_HUNT_TIMEOUT_EN
    ,
    parameter int HUNT_TIMEOUT     = 1_000_000
`endif
) (
    input  logic                                   i_axi_clk,
    input  logic                                   i_axi_rst,
    input  logic                                   i_enable,
    input  logic                                   i_mode,
    input  logic [SEL_WIDTH-1:0]                   i_fixed_sel,
    input  logic [7:0]                             i_frames_per_slot,
    input  logic [NUM_SOURCES-1:0]                 i_axis_src_tuser,
    input  logic [NUM_SOURCES-1:0]                 i_axis_src_tvalid,
    input  logic [NUM_SOURCES-1:0]                 i_axis_src_tlast,
    input  logic [NUM_SOURCES*AXIS_DATA_WIDTH-1:0] i_axis_src_tdata,
    output logic [NUM_SOURCES-1:0]                 o_axis_src_tready,
    output logic                                   o_axis_out_tuser,
    output logic                                   o_axis_out_tvalid,
    output logic                                   o_axis_out_tlast,
    output logic [AXIS_DATA_WIDTH-1:0]             o_axis_out_tdata,
    input  logic                                   i_axis_out_tready,
    output logic [SEL_WIDTH-1:0]                   o_active_src,
    output logic                                   o_locked,
    output logic [SWITCH_CNT_WIDTH-1:0]            o_switch_count
`ifdef FPS_ARB_HUNT_TIMEOUT_EN
    ,
    output logic                                   o_hunt_timeout
`endif
);

    arb_state_t                  r_state;
    arb_state_t                  w_next_state;
    logic [SEL_WIDTH-1:0]        r_active;
    logic [SEL_WIDTH-1:0]        w_next_active;
    logic [7:0]                  r_frame_cnt;
    logic [SWITCH_CNT_WIDTH-1:0] r_switch_count;
    logic                        r_out_hold;
    logic                        w_switch;
    logic                        w_sel_tready;

    logic                        w_sel_tuser;
    logic                        w_sel_tvalid;
    logic                        w_sel_tlast;
    logic [AXIS_DATA_WIDTH-1:0]  w_sel_tdata;

    axis_src_mux #(
        .NUM_SOURCES     (NUM_SOURCES),
        .AXIS_DATA_WIDTH (AXIS_DATA_WIDTH)
    ) u_mux (
        .i_sel          (r_active),
        .i_src_tuser    (i_axis_src_tuser),
        .i_src_tvalid   (i_axis_src_tvalid),
        .i_src_tlast    (i_axis_src_tlast),
        .i_src_tdata    (i_axis_src_tdata),
        .o_src_tready   (o_axis_src_tready),
        .i_sel_tready   (w_sel_tready & i_axi_rst),
        .i_drain_tready (i_axi_rst),
        .o_tuser        (w_sel_tuser),
        .o_tvalid       (w_sel_tvalid),
        .o_tlast        (w_sel_tlast),
        .o_tdata        (w_sel_tdata)
    );

    logic                 w_sel_ok;
    logic                 w_slot_done;
    logic                 w_pending;
    logic                 w_sof;
    logic                 w_block;
    logic                 w_pass;
    logic [SEL_WIDTH-1:0] w_rr_next;

    assign w_sel_ok    = int'(i_fixed_sel) < NUM_SOURCES;
    assign w_rr_next   = rr_next(r_active, NUM_SOURCES);
    assign w_slot_done = r_frame_cnt >= ((i_frames_per_slot == 8'd0) ? 8'd1 : i_frames_per_slot);
    assign w_pending   = !i_enable
                       || (i_mode == MODE_FIXED && w_sel_ok && i_fixed_sel != r_active)
                       || (i_mode == MODE_RR && w_slot_done);
    assign w_sof       = w_sel_tvalid & w_sel_tuser;
    assign w_pass      = (r_state == ST_PASS);
    // A beat already offered downstream must not be retracted, so hold off decisions.
    assign w_block     = w_pass && w_pending && !r_out_hold && w_sof;

    assign o_axis_out_tvalid = w_pass & w_sel_tvalid & !w_block;
    assign o_axis_out_tuser  = w_pass & w_sel_tuser;
    assign o_axis_out_tlast  = w_pass & w_sel_tlast;
    assign o_axis_out_tdata  = w_pass ? w_sel_tdata : '0;
    assign o_active_src      = r_active;
    assign o_locked          = w_pass;
    assign o_switch_count    = r_switch_count;

`ifdef FPS_ARB_HUNT_TIMEOUT_EN
    localparam int HT_W = $clog2(HUNT_TIMEOUT + 1);
    logic [HT_W-1:0] r_hunt_cnt;
    logic            r_hunt_timeout;
    logic            w_timeout_adv;
    assign o_hunt_timeout = r_hunt_timeout;
`endif

    always_comb begin
        w_next_state  = r_state;
        w_next_active = r_active;
        w_switch      = 1'b0;
        w_sel_tready  = 1'b0;
`ifdef FPS_ARB_HUNT_TIMEOUT_EN
        w_timeout_adv = 1'b0;
`endif
        case (r_state)
            ST_DISABLED: begin
                w_sel_tready = 1'b1;
                if (i_enable) begin
                    w_next_state = ST_HUNT;
                    if (i_mode == MODE_FIXED && w_sel_ok)
                        w_next_active = i_fixed_sel;
                end
            end
            ST_HUNT: begin
                w_sel_tready = !w_sof;
                if (!i_enable)
                    w_next_state = ST_DISABLED;
                else if (w_sof)
                    w_next_state = ST_PASS;
`ifdef FPS_ARB_HUNT_TIMEOUT_EN
                else if (r_hunt_cnt == HT_W'(HUNT_TIMEOUT - 1)) begin
                    w_timeout_adv = 1'b1;
                    w_next_active = w_rr_next;
                end
`endif
            end
            ST_PASS: begin
                w_sel_tready = w_block ? 1'b0 : i_axis_out_tready;
                if (w_block) begin
                    if (i_enable) begin
                        w_next_state  = ST_HUNT;
                        w_switch      = 1'b1;
                        w_next_active = (i_mode == MODE_RR) ? w_rr_next : i_fixed_sel;
                    end else begin
                        w_next_state = ST_DISABLED;
                    end
                end
            end
            default: w_next_state = ST_DISABLED;
        endcase
    end

    always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
        if (!i_axi_rst) begin
            r_state        <= ST_DISABLED;
            r_active       <= '0;
            r_frame_cnt    <= '0;
            r_switch_count <= '0;
            r_out_hold     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state    <= w_next_state;
            r_active   <= w_next_active;
            r_out_hold <= o_axis_out_tvalid & !i_axis_out_tready;
            if (w_block)
                r_frame_cnt <= '0;
            else if (o_axis_out_tvalid && i_axis_out_tready && w_sel_tuser && r_frame_cnt != 8'hFF)
                r_frame_cnt <= r_frame_cnt + 8'd1;
            if (w_switch)
                r_switch_count <= r_switch_count + 1'b1;
        end
    end

`ifdef FPS_ARB_HUNT_TIMEOUT_EN
    always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
        if (!i_axi_rst) begin
            r_hunt_cnt     <= '0;
            r_hunt_timeout <= 1'b0;
        end else begin
            if (r_state == ST_HUNT && w_next_state == ST_HUNT && !w_timeout_adv)
                r_hunt_cnt <= r_hunt_cnt + 1'b1;
            else
                r_hunt_cnt <= '0;
            if (w_timeout_adv)
                r_hunt_timeout <= 1'b1;
        end
    end
`endif

endmodule
